// File: rtl/mem_pkg.sv
// Shared definitions for the CPU data-memory interface: responder states,
// word geometry and the address legality check.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;

    // An address is illegal when it is not word aligned or has bits set above
    // the implemented word range.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned addr_width);
        logic [31:0] hi_bits;
        hi_bits = addr >> (addr_width + 2);
        return (addr[1:0] != 2'b00) || (hi_bits != 32'd0);
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response channel between the CPU memory stage (master) and the
// data memory (slave).
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_array.sv
// Single-port 32-bit RAM with per-byte write enables and registered read.
// Each byte lane is its own array so every lane maps onto plain block RAM.
module mem_array
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];
        logic [7:0] rdata_reg;

        always_ff @(posedge clk) begin
            if (en) begin
                if (we) begin
                    if (be[gi]) begin
                        lane_mem[addr] <= wdata[8*gi +: 8];
                    end
                end else begin
                    rdata_reg <= lane_mem[addr];
                end
            end
        end

        assign rdata[8*gi +: 8] = rdata_reg;
    end
endmodule

// File: rtl/mem_responder.sv
// Data-memory responder: one outstanding request, fixed wait states, byte-masked
// stores, and error flagging for misaligned or out-of-range addresses.
module mem_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int WAIT       = 2
) (
    input logic            clk,
    input logic            rst,
    mem_responder_if.slave bus
);
    import mem_pkg::*;

    localparam logic [3:0] CNT_INIT = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic        we_reg;
    logic [31:0] addr_reg, wdata_reg;
    logic [3:0]  be_reg;
    logic        err_reg;
    logic        rd_ok_reg;

    logic        accept, commit;
    logic        c_we, c_err;
    logic [31:0] c_addr, c_wdata;
    logic [3:0]  c_be;
    logic [31:0] ram_rdata;

    assign bus.req_ready = (state_reg == mem_pkg::IDLE) && !rst;
    assign accept        = bus.req_valid && bus.req_ready;
    assign bus.rsp_valid = (state_reg == mem_pkg::RESP);
    assign bus.rsp_err   = err_reg;
    // The RAM output register is not reset, so load data is gated by a flag
    // that is cleared on reset, on stores and on errors.
    assign bus.rsp_rdata = rd_ok_reg ? ram_rdata : 32'd0;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        commit     = 1'b0;
        c_we       = we_reg;
        c_addr     = addr_reg;
        c_wdata    = wdata_reg;
        c_be       = be_reg;
        case (state_reg)
            mem_pkg::IDLE: begin
                // With no wait states the commit happens on the acceptance
                // edge, straight from the request inputs.
                c_we    = bus.req_we;
                c_addr  = bus.req_addr;
                c_wdata = bus.req_wdata;
                c_be    = bus.req_be;
                if (accept) begin
                    if (WAIT == 0) begin
                        state_next = mem_pkg::RESP;
                        commit     = 1'b1;
                    end else begin
                        state_next = mem_pkg::WAIT;
                        cnt_next   = CNT_INIT;
                    end
                end
            end
            mem_pkg::WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = mem_pkg::RESP;
                    commit     = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            mem_pkg::RESP: begin
                if (bus.rsp_ready) begin
                    state_next = mem_pkg::IDLE;
                end
            end
            default: state_next = mem_pkg::IDLE;
        endcase
        c_err = addr_err(c_addr, ADDR_WIDTH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= mem_pkg::IDLE;
            cnt_reg   <= 4'd0;
            we_reg    <= 1'b0;
            addr_reg  <= 32'd0;
            wdata_reg <= 32'd0;
            be_reg    <= 4'd0;
            err_reg   <= 1'b0;
            rd_ok_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                we_reg    <= bus.req_we;
                addr_reg  <= bus.req_addr;
                wdata_reg <= bus.req_wdata;
                be_reg    <= bus.req_be;
            end
            if (commit) begin
                err_reg   <= c_err;
                rd_ok_reg <= !c_we && !c_err;
            end
        end
    end

    mem_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem_array (
        .clk  (clk),
        .en   (commit && !c_err && !rst),
        .we   (c_we),
        .be   (c_be),
        .addr (c_addr[ADDR_WIDTH+1:2]),
        .wdata(c_wdata),
        .rdata(ram_rdata)
    );
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: WAIT=2 responder for functional/timing cases, WAIT=0
// responder for back-to-back throughput with the response side always ready.
module tb_mem_responder;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_responder_if b0();
    mem_responder_if b1();

    mem_responder #(.ADDR_WIDTH(8), .WAIT(2)) u_dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
    mem_responder #(.ADDR_WIDTH(8), .WAIT(0)) u_dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Full transaction on the WAIT=2 responder, called at #1 after an edge.
    task automatic do_req(input string name, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input logic [31:0] exp_rdata, input logic exp_err);
        int n;
        b0.req_we    = we;
        b0.req_addr  = addr;
        b0.req_wdata = wdata;
        b0.req_be    = be;
        b0.req_valid = 1'b1;
        n = 0;
        while (!b0.req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 20) begin
            check({name, " accept timeout"}, 32'd1, 32'd0);
            b0.req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        b0.req_valid = 1'b0;
        n = 0;
        while (!b0.rsp_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check({name, " latency"}, n, 32'd2);
        check({name, " rdata"}, b0.rsp_rdata, exp_rdata);
        check({name, " err"}, b0.rsp_err, exp_err);
        $display("txn %s we=%0d addr=0x%08h wdata=0x%08h be=0x%h -> rdata=0x%08h err=%0d lat=%0d",
                 name, we, addr, wdata, be, b0.rsp_rdata, b0.rsp_err, n);
        b0.rsp_ready = 1'b1;
        @(posedge clk); #1;
        b0.rsp_ready = 1'b0;
        check({name, " req_ready after rsp"}, b0.req_ready, 32'd1);
    endtask

    logic [31:0] v_addr  [5];
    logic [31:0] v_wdata [5];
    logic        v_we    [5];
    logic [31:0] v_rdata [5];
    logic        v_err   [5];
    int          acc_cyc [5];
    int          rsp_cyc [5];
    logic [31:0] rsp_d   [5];
    logic        rsp_e   [5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        int  nacc;
        int  nrsp;
        logic acc;

        b0.req_valid = 1'b0; b0.req_we = 1'b0; b0.req_addr = '0;
        b0.req_wdata = '0;   b0.req_be = '0;   b0.rsp_ready = 1'b0;
        b1.req_valid = 1'b0; b1.req_we = 1'b0; b1.req_addr = '0;
        b1.req_wdata = '0;   b1.req_be = '0;   b1.rsp_ready = 1'b1;

        // Reset state
        #12;
        check("reset req_ready", b0.req_ready, 32'd0);
        check("reset rsp_valid", b0.rsp_valid, 32'd0);
        check("reset rsp_rdata", b0.rsp_rdata, 32'd0);
        check("reset rsp_err",   b0.rsp_err,   32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post-reset req_ready", b0.req_ready, 32'd1);

        // Basic store/load
        do_req("st10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        do_req("ld10", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

        // Byte-lane merge
        do_req("st14", 1'b1, 32'h14, 32'h11223344, 4'hF, 32'h0, 1'b0);
        do_req("st14_be5", 1'b1, 32'h14, 32'hAABBCCDD, 4'h5, 32'h0, 1'b0);
        do_req("ld14", 1'b0, 32'h14, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);
        do_req("st14_be0", 1'b1, 32'h14, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0);
        do_req("ld14_b", 1'b0, 32'h14, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);

        // Errors: misaligned and out of range, no side effects
        do_req("ld13_mis", 1'b0, 32'h13, 32'h0, 4'h0, 32'h0, 1'b1);
        do_req("st00", 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
        do_req("st400_oor", 1'b1, 32'h400, 32'h12345678, 4'hF, 32'h0, 1'b1);
        do_req("ld00", 1'b0, 32'h400 & 32'h3FC, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);
        do_req("st11_mis", 1'b1, 32'h11, 32'h0, 4'hF, 32'h0, 1'b1);
        do_req("ld10_b", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

        // Back-pressure in RESP with a competing request pending
        b0.req_we = 1'b0; b0.req_addr = 32'h10; b0.req_be = 4'h0; b0.req_valid = 1'b1;
        @(posedge clk); #1;
        b0.req_valid = 1'b0;
        n = 0;
        while (!b0.rsp_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("hold latency", n, 32'd2);
        b0.req_we = 1'b1; b0.req_addr = 32'h10; b0.req_wdata = 32'h0; b0.req_be = 4'hF;
        b0.req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold rsp_valid", b0.rsp_valid, 32'd1);
            check("hold rsp_rdata", b0.rsp_rdata, 32'hDEADBEEF);
            check("hold req_ready", b0.req_ready, 32'd0);
        end
        b0.req_valid = 1'b0;
        b0.rsp_ready = 1'b1;
        @(posedge clk); #1;
        b0.rsp_ready = 1'b0;
        check("release rsp_valid", b0.rsp_valid, 32'd0);
        check("release req_ready", b0.req_ready, 32'd1);
        $display("txn hold: load 0x10 held 5 cycles, competing store not accepted");
        do_req("ld10_c", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

        // Reset during WAIT discards the pending store
        do_req("st20", 1'b1, 32'h20, 32'h0, 4'hF, 32'h0, 1'b0);
        do_req("ld10_d", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
        b0.req_we = 1'b1; b0.req_addr = 32'h20; b0.req_wdata = 32'hFFFFFFFF; b0.req_be = 4'hF;
        b0.req_valid = 1'b1;
        @(posedge clk); #1;
        b0.req_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async rst req_ready", b0.req_ready, 32'd0);
        check("async rst rsp_valid", b0.rsp_valid, 32'd0);
        check("async rst rsp_rdata", b0.rsp_rdata, 32'd0);
        check("async rst rsp_err",   b0.rsp_err,   32'd0);
        $display("txn reset asserted during WAIT of store 0x20");
        @(posedge clk); @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst release req_ready", b0.req_ready, 32'd1);
        do_req("ld20", 1'b0, 32'h20, 32'h0, 4'h0, 32'h0, 1'b0);

        // WAIT=0 back-to-back, response side always ready
        v_we[0] = 1'b1; v_addr[0] = 32'h40;              v_wdata[0] = 32'hA5A5A5A5; v_rdata[0] = 32'h0;        v_err[0] = 1'b0;
        v_we[1] = 1'b1; v_addr[1] = 32'h40 + WORD_BYTES; v_wdata[1] = 32'h5A5A5A5A; v_rdata[1] = 32'h0;        v_err[1] = 1'b0;
        v_we[2] = 1'b0; v_addr[2] = 32'h40;              v_wdata[2] = 32'h0;        v_rdata[2] = 32'hA5A5A5A5; v_err[2] = 1'b0;
        v_we[3] = 1'b0; v_addr[3] = 32'h40 + WORD_BYTES; v_wdata[3] = 32'h0;        v_rdata[3] = 32'h5A5A5A5A; v_err[3] = 1'b0;
        v_we[4] = 1'b0; v_addr[4] = 32'h43;              v_wdata[4] = 32'h0;        v_rdata[4] = 32'h0;        v_err[4] = 1'b1;
        nacc = 0;
        nrsp = 0;
        b1.req_we = v_we[0]; b1.req_addr = v_addr[0]; b1.req_wdata = v_wdata[0]; b1.req_be = 4'hF;
        b1.req_valid = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (b1.rsp_valid && nrsp < 5) begin
                rsp_d[nrsp]   = b1.rsp_rdata;
                rsp_e[nrsp]   = b1.rsp_err;
                rsp_cyc[nrsp] = cyc;
                nrsp++;
            end
            acc = b1.req_valid && b1.req_ready;
            if (acc) acc_cyc[nacc] = cyc;
            @(posedge clk); #1;
            if (acc) begin
                nacc++;
                if (nacc < 5) begin
                    b1.req_we = v_we[nacc]; b1.req_addr = v_addr[nacc]; b1.req_wdata = v_wdata[nacc];
                end else begin
                    b1.req_valid = 1'b0;
                end
            end
        end
        check("b2b accepts", nacc, 32'd5);
        check("b2b responses", nrsp, 32'd5);
        if (nacc == 5 && nrsp == 5) begin
            for (int i = 0; i < 5; i++) begin
                check("b2b rdata", rsp_d[i], v_rdata[i]);
                check("b2b err", rsp_e[i], v_err[i]);
                check("b2b rsp latency", rsp_cyc[i] - acc_cyc[i], 32'd1);
                if (i > 0) check("b2b spacing", acc_cyc[i] - acc_cyc[i-1], 32'd2);
                $display("txn b2b[%0d] we=%0d addr=0x%08h acc@%0d rsp@%0d rdata=0x%08h err=%0d",
                         i, v_we[i], v_addr[i], acc_cyc[i], rsp_cyc[i], rsp_d[i], rsp_e[i]);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
# mem_responder

Word-organised data memory that answers load/store requests from the CPU's memory stage over a valid/ready request channel and a valid/ready response channel. It is the responder side of the CPU data-memory interface. It accepts one request at a time and applies a fixed, parameterised number of wait states. It commits byte-lane-masked writes and flags misaligned or out-of-range addresses.

## Interface
- ADDR_WIDTH, 8, word-address bits; storage depth is 2**ADDR_WIDTH words of 32 bits
- WAIT, 2, wait-state cycles between request acceptance and response (0 to 15)
- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  initiator presents a request
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- req_be  in  4  byte-lane enables for stores; bit i covers wdata[8i+7:8i]
- rsp_valid  out  1  response available
- rsp_ready  in  1  initiator accepts the response
- rsp_rdata  out  32  load data; 0 for stores and for errors
- rsp_err  out  1  request was misaligned or out of range

## Operation
- FSM states: IDLE, WAIT, RESP. Reset enters IDLE.
- IDLE:
  - req_ready = 1, except while rst is high.
  - On req_valid && req_ready, latch we, addr, wdata and be.
  - Go to WAIT with cnt = WAIT-1. If WAIT = 0, go directly to RESP.
- WAIT:
  - req_ready = 0.
  - Decrement cnt each cycle.
  - When cnt = 0, go to RESP and perform the commit on that edge.
- Commit:
  - err = (addr[1:0] != 0) || (addr[31:ADDR_WIDTH+2] != 0).
  - Store with no error: write each lane whose be bit is set; other lanes keep their prior value. be = 0 is a legal no-op.
  - Load with no error: rsp_rdata = mem[addr[ADDR_WIDTH+1:2]].
  - Any error: no write occurs, rsp_rdata = 0, rsp_err = 1.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err stay stable until the handshake.
  - On rsp_ready, go to IDLE.
- One outstanding request only. req_ready is low from the acceptance edge until the cycle after the response handshake.
- Memory contents are not reset and are X until first written.

## Timing
- Request accepted at edge k:
  - rsp_valid is high in the cycle after edge k+WAIT (k+1 when WAIT = 0 means the cycle directly after acceptance).
  - The store is visible to any later load from the commit edge onward.
- A response handshake at edge m makes req_ready high in the cycle after m. Minimum request spacing is WAIT+2 cycles.
- rsp_ready held low: RESP holds indefinitely with outputs frozen.
- Reset values: req_ready 0 while rst is high, then 1; rsp_valid 0; rsp_rdata 0; rsp_err 0; state IDLE; cnt 0.
- Reset mid-operation:
  - Asserted in WAIT: the pending store is discarded with no partial write.
  - Asserted in RESP: an already-committed store persists, and the response is dropped.
- req_valid while not ready: ignored. The initiator must hold the request.
- rsp_ready outside RESP: ignored.

## Structure
- Shared package mem_pkg holds:
  - state enum (IDLE, WAIT, RESP)
  - WORD_BYTES = 4
  - function addr_err(addr, ADDR_WIDTH)
- The cpu and the bench reuse the package.
- Sub-module mem_array: synchronous single-port RAM, 32-bit words, 4 byte-write enables, read data registered on the same edge.
- The FSM, wait counter and error check live in mem_responder.

## Test plan
- WAIT=2, store addr 0x10, data 0xDEADBEEF, be 0xF, then load 0x10 → rsp_rdata 0xDEADBEEF, rsp_err 0; rsp_valid rises the cycle after edge k+2.
- Store 0x11223344 be 0xF, then store 0xAABBCCDD be 0x5 to the same word, then load → 0x11BB33DD.
- Load addr 0x13 (misaligned), and store to 0x400 with ADDR_WIDTH 8 (out of range) → rsp_err 1, rsp_rdata 0; the following load of word 0x400 & 0x3FC is unchanged.
- Hold rsp_ready low 5 cycles in RESP → rsp_valid and rsp_rdata stable, req_ready 0, new req_valid not accepted; release → IDLE next cycle.
- Assert rst during WAIT of a store to 0x20 holding 0x0 → after reset, a load of 0x20 returns 0x0, and all outputs took their reset values asynchronously.
- WAIT=0 back-to-back with rsp_ready tied 1 → requests accepted every 2 cycles, responses in order.
